circle_motion_ctrl: RTL and testbench
=====================================

CIRCLE_MOTION_CTRL -- requirements
Module: circle_motion_ctrl

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 500000, the stable-input time in clk50 cycles (10 ms) before a button change is accepted.
REQ-002 SHALL have parameter STEP, default 2, the pixels moved per axis per position update.
REQ-003 SHALL have parameter FRAMES_PER_STEP, default 1, the number of frame ticks between position updates while a button is held.
REQ-004 SHALL have parameter RADIUS, default 20, the circle radius in pixels, used for clamping.
REQ-005 SHALL have port clk50, input, 1, the single 50 MHz system clock; all logic is on its rising edge.
REQ-006 SHALL have port reset, input, 1, a synchronous active-high reset.
REQ-007 SHALL have ports movUp, movDown, movLeft, movRight, each input, 1, raw active-high buttons that are asynchronous to clk50.
REQ-008 SHALL have port Vsync, input, 1, the active-low vertical sync from the VGA controller.
REQ-009 SHALL have port CircleRow, output, 9, the registered circle-centre row (0..479).
REQ-010 SHALL have port CircleCol, output, 10, the registered circle-centre column (0..639).
REQ-011 SHALL have port moving, output, 1, high while the FSM is in WAIT_FRAME or UPDATE.

Function
REQ-012 SHALL pass each button through a 2-flop synchronizer before any other logic.
REQ-013 SHALL debounce each synchronized button with its own counter, built as follows:
- The counter clears whenever the synced value equals the debounced value.
- The debounced value takes the synced value once the counter reaches DEBOUNCE_CYCLES-1 with the synced value unchanged.
REQ-014 SHALL generate a one-cycle frame_tick in the cycle after a Vsync falling edge (registered edge detect).
REQ-015 SHALL compute the per-axis direction from the debounced buttons:
- Up alone gives dy=-STEP; Down alone gives dy=+STEP; both or neither give dy=0.
- The dx axis follows the same rule, with Left giving -STEP and Right giving +STEP.
REQ-016 SHALL define active as (dx!=0 or dy!=0).
REQ-017 SHALL implement a FSM with states IDLE, WAIT_FRAME and UPDATE.
REQ-018 SHALL transition IDLE->WAIT_FRAME when active, and SHALL load the frame counter with FRAMES_PER_STEP-1.
REQ-019 SHALL, in WAIT_FRAME, return to IDLE when active drops, with no position change.
REQ-020 SHALL, in WAIT_FRAME on frame_tick, go to UPDATE if the frame counter is 0; otherwise it SHALL decrement the counter and stay in WAIT_FRAME.
REQ-021 SHALL, in UPDATE (exactly one cycle), apply dx and dy and then:
- go to WAIT_FRAME with the counter reloaded when active;
- go to IDLE otherwise.
REQ-022 SHALL use the dx and dy values sampled in the UPDATE cycle.
REQ-023 SHALL perform position arithmetic in signed 12-bit, then clamp:
- Col to [RADIUS, 639-RADIUS];
- Row to [RADIUS, 479-RADIUS].
REQ-024 SHALL never wrap a position, and SHALL saturate a step that would cross a limit at that limit.
REQ-025 SHALL update CircleRow/CircleCol only on the clock edge ending UPDATE, so they change at most once per frame and never mid-frame.
REQ-026 SHALL ignore a frame_tick that coincides with the IDLE->WAIT_FRAME transition; counting starts at the next tick.
REQ-027 SHALL ignore Vsync entirely in IDLE.

Reset
REQ-028 SHALL, while reset=1 at a clock edge, force the following, with reset taking priority over every other event:
- state=IDLE, CircleRow=240, CircleCol=320, moving=0;
- all debounced values=0, synchronizers=0, debounce and frame counters=0, Vsync edge register=1.
REQ-029 SHALL, when reset is asserted during WAIT_FRAME or UPDATE, abort the step and lose no more than the pending update.

Verification
REQ-030 SHALL be covered by a reset test: assert reset for 2 cycles at any state -> next cycle CircleRow=240, CircleCol=320, moving=0.
REQ-031 SHALL be covered by a right-press test with DEBOUNCE_CYCLES=4 and STEP=2: hold movRight, apply 3 Vsync pulses -> CircleCol goes 322, 324, 326, each change exactly 2 cycles after its Vsync falling edge, and CircleRow stays 240.
REQ-032 SHALL be covered by a bounce test: movUp toggling every 2 cycles for 20 cycles, then low -> debounced value stays 0, moving stays 0, CircleRow stays 240.
REQ-033 SHALL be covered by a clamp test: hold movLeft for 200 frames from Col=320 -> CircleCol reaches 20 and stays there; then hold movDown from Row=240 -> CircleRow saturates at 459.
REQ-034 SHALL be covered by an opposing-press test: movUp and movDown held together across 5 frames -> CircleRow unchanged and moving=0; adding movRight -> only the column advances.
REQ-035 SHALL be covered by a rate test: FRAMES_PER_STEP=3 with movDown held for 9 frame ticks after arming -> exactly 3 updates, CircleRow=246; releasing in WAIT_FRAME gives no further change.

Source files
------------

// File: rtl/circle_motion_ctrl.sv
// Button-driven circle-centre controller for a 640x480 VGA display.
// Buttons are synchronized and debounced, then the position steps once per frame (or every N frames).

module cmc_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk50,
    input  logic reset,
    input  logic btn_i,
    output logic deb_o
);
    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic [1:0]    sync_q, sync_d;
    logic          deb_q, deb_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        sync_d = {sync_q[0], btn_i};
        deb_d  = deb_q;
        cnt_d  = cnt_q;
        if (sync_q[1] == deb_q) begin
            cnt_d = '0;
        end else if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
            deb_d = sync_q[1];
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk50) begin
        if (reset) begin
            sync_q <= '0;
            deb_q  <= 1'b0;
            cnt_q  <= '0;
        end else begin
            sync_q <= sync_d;
            deb_q  <= deb_d;
            cnt_q  <= cnt_d;
        end
    end

    assign deb_o = deb_q;
endmodule

module circle_motion_ctrl #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int STEP            = 2,
    parameter int FRAMES_PER_STEP = 1,
    parameter int RADIUS          = 20
) (
    input  logic       clk50,
    input  logic       reset,
    input  logic       movUp,
    input  logic       movDown,
    input  logic       movLeft,
    input  logic       movRight,
    input  logic       Vsync,
    output logic [8:0] CircleRow,
    output logic [9:0] CircleCol,
    output logic       moving
);
    localparam int NUM_BTN = 4;
    localparam int FW      = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;

    localparam logic signed [11:0] STEP_S  = 12'(STEP);
    localparam logic signed [11:0] POS_MIN = 12'(RADIUS);
    localparam logic signed [11:0] COL_MAX = 12'(639 - RADIUS);
    localparam logic signed [11:0] ROW_MAX = 12'(479 - RADIUS);
    localparam logic [FW-1:0]      RELOAD  = FW'(FRAMES_PER_STEP - 1);

    typedef enum logic [1:0] {IDLE, WAIT_FRAME, UPDATE} state_t;

    // bit order: 0=up 1=down 2=left 3=right
    logic [NUM_BTN-1:0] btn_raw, deb;
    assign btn_raw = {movRight, movLeft, movDown, movUp};

    genvar g;
    generate
        for (g = 0; g < NUM_BTN; g++) begin : g_btn
            cmc_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
                .clk50 (clk50),
                .reset (reset),
                .btn_i (btn_raw[g]),
                .deb_o (deb[g])
            );
        end
    endgenerate

    state_t          state_q, state_d;
    logic [FW-1:0]   fcnt_q, fcnt_d;
    logic [8:0]      row_q, row_d;
    logic [9:0]      col_q, col_d;
    logic            vs_q, vs_d;
    logic            tick_q, tick_d;
    logic signed [11:0] dx, dy, row_sum, col_sum;
    logic [8:0]      row_clamp;
    logic [9:0]      col_clamp;
    logic            active;

    assign vs_d   = Vsync;
    assign tick_d = vs_q & ~Vsync;

    always_comb begin
        dy = '0;
        dx = '0;
        if (deb[0] && !deb[1]) dy = -STEP_S;
        else if (deb[1] && !deb[0]) dy = STEP_S;
        if (deb[2] && !deb[3]) dx = -STEP_S;
        else if (deb[3] && !deb[2]) dx = STEP_S;
    end

    assign active = (dx != 0) || (dy != 0);

    // Saturating arithmetic: a step that would overshoot lands exactly on the limit.
    always_comb begin
        col_sum = $signed({2'b00, col_q}) + dx;
        row_sum = $signed({3'b000, row_q}) + dy;
        if (col_sum < POS_MIN)      col_clamp = 10'(RADIUS);
        else if (col_sum > COL_MAX) col_clamp = 10'(639 - RADIUS);
        else                        col_clamp = col_sum[9:0];
        if (row_sum < POS_MIN)      row_clamp = 9'(RADIUS);
        else if (row_sum > ROW_MAX) row_clamp = 9'(479 - RADIUS);
        else                        row_clamp = row_sum[8:0];
    end

    always_comb begin
        state_d = state_q;
        fcnt_d  = fcnt_q;
        row_d   = row_q;
        col_d   = col_q;
        case (state_q)
            IDLE: begin
                if (active) begin
                    state_d = WAIT_FRAME;
                    fcnt_d  = RELOAD;
                end
            end
            WAIT_FRAME: begin
                if (!active) begin
                    state_d = IDLE;
                end else if (tick_q) begin
                    if (fcnt_q == '0) state_d = UPDATE;
                    else              fcnt_d  = fcnt_q - 1'b1;
                end
            end
            UPDATE: begin
                row_d = row_clamp;
                col_d = col_clamp;
                if (active) begin
                    state_d = WAIT_FRAME;
                    fcnt_d  = RELOAD;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk50) begin
        if (reset) begin
            state_q <= IDLE;
            fcnt_q  <= '0;
            row_q   <= 9'd240;
            col_q   <= 10'd320;
            vs_q    <= 1'b1;
            tick_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
            row_q   <= row_d;
            col_q   <= col_d;
            vs_q    <= vs_d;
            tick_q  <= tick_d;
        end
    end

    assign CircleRow = row_q;
    assign CircleCol = col_q;
    assign moving    = (state_q != IDLE);
endmodule

// File: tb/tb_circle_motion_ctrl.sv
// Directed bench: one instance at one step per frame, a second at three frames per step.
module tb_circle_motion_ctrl;
    logic       clk50 = 1'b0;
    logic       reset = 1'b1;
    logic       movUp = 1'b0, movDown = 1'b0, movLeft = 1'b0, movRight = 1'b0;
    logic       Vsync = 1'b1;
    logic [8:0] row, row3;
    logic [9:0] col, col3;
    logic       moving, moving3;

    int n_checks = 0;
    int n_fail   = 0;

    always #10 clk50 = ~clk50;

    circle_motion_ctrl #(.DEBOUNCE_CYCLES(4), .STEP(2), .FRAMES_PER_STEP(1), .RADIUS(20)) dut (
        .clk50(clk50), .reset(reset), .movUp(movUp), .movDown(movDown),
        .movLeft(movLeft), .movRight(movRight), .Vsync(Vsync),
        .CircleRow(row), .CircleCol(col), .moving(moving)
    );

    circle_motion_ctrl #(.DEBOUNCE_CYCLES(4), .STEP(2), .FRAMES_PER_STEP(3), .RADIUS(20)) dut3 (
        .clk50(clk50), .reset(reset), .movUp(movUp), .movDown(movDown),
        .movLeft(movLeft), .movRight(movRight), .Vsync(Vsync),
        .CircleRow(row3), .CircleCol(col3), .moving(moving3)
    );

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk50);
            #1;
        end
    endtask

    task automatic frame();
        Vsync = 1'b0;
        step(2);
        Vsync = 1'b1;
        step(4);
    endtask

    task automatic do_reset();
        movUp = 0; movDown = 0; movLeft = 0; movRight = 0;
        Vsync = 1'b1;
        reset = 1'b1;
        step(2);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (row !== 9'd240) begin n_fail++; $display("FAIL reset_row got %0d want 240", row); end
        n_checks++; if (col !== 10'd320) begin n_fail++; $display("FAIL reset_col got %0d want 320", col); end
        n_checks++; if (moving !== 1'b0) begin n_fail++; $display("FAIL reset_moving got %b want 0", moving); end
        n_checks++; if (row3 !== 9'd240 || col3 !== 10'd320) begin n_fail++; $display("FAIL reset_dut3 got %0d,%0d want 240,320", row3, col3); end
        // move once, then reset while an update is pending
        movRight = 1'b1;
        for (int i = 0; i < 20 && moving !== 1'b1; i++) step(1);
        n_checks++; if (moving !== 1'b1) begin n_fail++; $display("FAIL reset_arm moving got %b want 1", moving); end
        frame();
        n_checks++; if (col !== 10'd322) begin n_fail++; $display("FAIL reset_premove col got %0d want 322", col); end
        Vsync = 1'b0;
        step(1);
        reset = 1'b1;
        step(2);
        reset = 1'b0;
        n_checks++; if (row !== 9'd240 || col !== 10'd320) begin n_fail++; $display("FAIL reset_mid got %0d,%0d want 240,320", row, col); end
        n_checks++; if (moving !== 1'b0) begin n_fail++; $display("FAIL reset_mid_moving got %b want 0", moving); end
        step(1);
        n_checks++; if (col !== 10'd320 || moving !== 1'b0) begin n_fail++; $display("FAIL reset_no_pending col=%0d moving=%b want 320,0", col, moving); end
        movRight = 1'b0;
        Vsync = 1'b1;
        step(10);
    endtask

    task automatic test_right_press();
        do_reset();
        movRight = 1'b1;
        for (int i = 0; i < 20 && moving !== 1'b1; i++) step(1);
        n_checks++; if (moving !== 1'b1) begin n_fail++; $display("FAIL right_arm moving got %b want 1", moving); end
        for (int k = 1; k <= 3; k++) begin
            Vsync = 1'b0;
            step(2);
            n_checks++; if (col !== 10'(320 + 2 * (k - 1))) begin n_fail++; $display("FAIL right_early%0d col got %0d want %0d", k, col, 320 + 2 * (k - 1)); end
            step(1);
            n_checks++; if (col !== 10'(320 + 2 * k)) begin n_fail++; $display("FAIL right_step%0d col got %0d want %0d", k, col, 320 + 2 * k); end
            n_checks++; if (row !== 9'd240) begin n_fail++; $display("FAIL right_row%0d got %0d want 240", k, row); end
            Vsync = 1'b1;
            step(3);
        end
        movRight = 1'b0;
        step(10);
        n_checks++; if (moving !== 1'b0 || col !== 10'd326) begin n_fail++; $display("FAIL right_release moving=%b col=%0d want 0,326", moving, col); end
    endtask

    task automatic test_bounce();
        do_reset();
        for (int i = 0; i < 10; i++) begin
            movUp = ~movUp;
            step(2);
            n_checks++; if (moving !== 1'b0 || row !== 9'd240) begin n_fail++; $display("FAIL bounce%0d moving=%b row=%0d want 0,240", i, moving, row); end
        end
        movUp = 1'b0;
        step(10);
        frame();
        n_checks++; if (moving !== 1'b0 || row !== 9'd240) begin n_fail++; $display("FAIL bounce_end moving=%b row=%0d want 0,240", moving, row); end
    endtask

    task automatic test_clamp();
        do_reset();
        movLeft = 1'b1;
        for (int i = 0; i < 20 && moving !== 1'b1; i++) step(1);
        n_checks++; if (moving !== 1'b1) begin n_fail++; $display("FAIL clamp_arm moving got %b want 1", moving); end
        for (int f = 1; f <= 200; f++) begin
            frame();
            if (f == 149) begin
                n_checks++; if (col !== 10'd22) begin n_fail++; $display("FAIL clamp_col149 got %0d want 22", col); end
            end
            if (f == 150) begin
                n_checks++; if (col !== 10'd20) begin n_fail++; $display("FAIL clamp_col150 got %0d want 20", col); end
            end
        end
        n_checks++; if (col !== 10'd20 || row !== 9'd240) begin n_fail++; $display("FAIL clamp_col_hold got %0d,%0d want 20,240", col, row); end
        movLeft = 1'b0;
        movDown = 1'b1;
        step(10);
        n_checks++; if (moving !== 1'b1) begin n_fail++; $display("FAIL clamp_down_arm moving got %b want 1", moving); end
        for (int f = 1; f <= 120; f++) begin
            frame();
            if (f == 109) begin
                n_checks++; if (row !== 9'd458) begin n_fail++; $display("FAIL clamp_row109 got %0d want 458", row); end
            end
            if (f == 110) begin
                n_checks++; if (row !== 9'd459) begin n_fail++; $display("FAIL clamp_row110 got %0d want 459", row); end
            end
        end
        n_checks++; if (row !== 9'd459 || col !== 10'd20) begin n_fail++; $display("FAIL clamp_row_hold got %0d,%0d want 459,20", row, col); end
        movDown = 1'b0;
        step(10);
    endtask

    task automatic test_opposing();
        do_reset();
        movUp = 1'b1;
        movDown = 1'b1;
        step(10);
        for (int f = 1; f <= 5; f++) begin
            frame();
            n_checks++; if (moving !== 1'b0 || row !== 9'd240) begin n_fail++; $display("FAIL opp_frame%0d moving=%b row=%0d want 0,240", f, moving, row); end
        end
        movRight = 1'b1;
        for (int i = 0; i < 20 && moving !== 1'b1; i++) step(1);
        n_checks++; if (moving !== 1'b1) begin n_fail++; $display("FAIL opp_arm moving got %b want 1", moving); end
        for (int f = 1; f <= 3; f++) begin
            frame();
            n_checks++; if (col !== 10'(320 + 2 * f) || row !== 9'd240) begin n_fail++; $display("FAIL opp_col%0d got %0d,%0d want %0d,240", f, col, row, 320 + 2 * f); end
        end
        movUp = 0; movDown = 0; movRight = 0;
        step(10);
    endtask

    task automatic test_rate();
        do_reset();
        movDown = 1'b1;
        for (int i = 0; i < 20 && moving3 !== 1'b1; i++) step(1);
        n_checks++; if (moving3 !== 1'b1) begin n_fail++; $display("FAIL rate_arm moving got %b want 1", moving3); end
        for (int t = 1; t <= 9; t++) begin
            frame();
            n_checks++; if (row3 !== 9'(240 + 2 * (t / 3))) begin n_fail++; $display("FAIL rate_tick%0d row got %0d want %0d", t, row3, 240 + 2 * (t / 3)); end
        end
        frame();
        n_checks++; if (row3 !== 9'd246 || moving3 !== 1'b1) begin n_fail++; $display("FAIL rate_tick10 row=%0d moving=%b want 246,1", row3, moving3); end
        movDown = 1'b0;
        step(10);
        n_checks++; if (moving3 !== 1'b0) begin n_fail++; $display("FAIL rate_release moving got %b want 0", moving3); end
        for (int t = 0; t < 4; t++) frame();
        n_checks++; if (row3 !== 9'd246 || col3 !== 10'd320) begin n_fail++; $display("FAIL rate_idle got %0d,%0d want 246,320", row3, col3); end
    endtask

    initial begin
        test_reset();
        test_right_press();
        test_bounce();
        test_clamp();
        test_opposing();
        test_rate();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
